io_gpio_irq: RTL and testbench
==============================

Name: io_gpio_irq

Overview:
- Parametrised GPIO controller on the DMA/IO bus, successor to the fixed 4-pin LED/GPIO block.
- NGPIO pins, each with:
  - per-pin output enable
  - atomic set/clear of output bits
  - double-flop input synchroniser
  - optional glitch filter
  - per-pin rising/falling edge detection into sticky W1C status
- Single level interrupt output to the CPU.
- Sits in the IO read-data daisy chain: its read mux passes dma_io_rdata_in through when it is not addressed.

Parameters:
- NGPIO, 8, number of pins, 1..32.
- BASE_ADR, 14'h3F88, word address of register 0 (bus bits [15:2]); occupies BASE_ADR..BASE_ADR+7.
- DEB_CYCLES, 0, glitch-filter length in clk cycles; 0 = filter bypassed; max 255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dma_io_we  in  1  write strobe
- dma_io_wadr  in  14 [15:2]  write word address
- dma_io_wdata  in  32  write data
- dma_io_radr  in  14 [15:2]  read word address
- dma_io_radr_en  in  1  read strobe
- dma_io_rdata_in  in  32  read data from upstream chain
- dma_io_rdata  out  32  read data to downstream chain
- gpio_i  in  NGPIO  pad inputs, asynchronous
- gpio_o  out  NGPIO  pad output values (= OUT)
- gpio_en  out  NGPIO  pad output enables (= EN)
- gpio_irq  out  1  interrupt, active high

Behaviour:
- Clocking and reset:
  - One clock domain; reset is asynchronous and active-low (clk, rst_n).
  - All flops clear on reset, so gpio_o=0, gpio_en=0, gpio_irq=0 and all registers are 0.
  - Reset asserted mid-operation aborts filter counts and clears status immediately.
- Register map (word offset from BASE_ADR). Only bits [NGPIO-1:0] are implemented; upper bits read 0.
  - 0 OUT: RW.
  - 1 IN: RO, filtered input value; writes ignored.
  - 2 EN: RW.
  - 3 OUT_SET: WO; OUT |= wdata; reads 0.
  - 4 OUT_CLR: WO; OUT &= ~wdata; reads 0.
  - 5 RISE_EN: RW.
  - 6 FALL_EN: RW.
  - 7 STATUS: RW1C.
- Writes take effect at the clk edge where dma_io_we=1 and the address matches. Non-matching addresses are ignored.
- Read pipeline:
  - A read strobe with a matching address in cycle N sets a 1-cycle-delayed select.
  - In cycle N+1, dma_io_rdata = addressed register, zero-extended, using register contents as they are in cycle N+1.
  - Otherwise dma_io_rdata = dma_io_rdata_in, combinationally.
- Input path:
  - gpio_i passes through two sync flops to give s.
  - DEB_CYCLES=0: filtered value f = s, so a pin change is visible in IN 2 cycles later.
  - DEB_CYCLES=D>0: each pin has an 8-bit counter.
    - When s==f, the counter is 0.
    - When s!=f, the counter increments each cycle.
    - When s has differed from f for D consecutive cycles, f <= s and the counter clears.
    - Any return of s to f before then clears the counter (pulses shorter than D cycles are rejected).
    - f resets to 0.
- Edge detection:
  - f_d is f delayed one cycle; rise = f & ~f_d, fall = ~f & f_d.
  - STATUS[i] sets on the cycle after the edge when (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
  - Edges occurring while the enable bit is 0 are not remembered.
- STATUS clear:
  - A write to STATUS clears the bits where wdata=1.
  - If a set event and a W1C clear hit the same bit in the same cycle, set wins (bit stays 1).
- gpio_irq = |STATUS, driven from flops with no combinational path from the bus.
- Outputs: gpio_o = OUT and gpio_en = EN, directly from flops; an output changes on the clk edge after its write.

Test Plan:
- Reset: rst_n=0 with gpio_i=8'hFF -> gpio_o=0, gpio_en=0, gpio_irq=0. Read IN after release (DEB=0) in the cycle after the strobe -> 0x000000FF by 3 cycles after release. STATUS=0 because RISE_EN=0.
- Set/clear:
  - Write OUT=0xA5, OUT_SET=0x0F, OUT_CLR=0x81 -> gpio_o 0xA5, 0xAF, 0x2E on successive writes.
  - Reads of OUT_SET and OUT_CLR return 0.
  - A read of an unmapped address (BASE_ADR+8) returns dma_io_rdata_in=0xDEADBEEF.
- Edge interrupt:
  - RISE_EN=0x01, FALL_EN=0x02; toggle gpio_i[0] 0->1 -> STATUS=0x01 and gpio_irq=1 within 4 cycles.
  - Toggle gpio_i[1] 1->0 -> STATUS=0x03.
  - Write STATUS=0x01 -> STATUS=0x02, irq stays 1; write 0x02 -> irq=0.
- Simultaneous set/clear: force a rising edge on pin0 to be recorded in the same cycle as a W1C write of 0x01 -> STATUS[0]=1 and gpio_irq=1.
- Glitch filter (DEB_CYCLES=4, RISE_EN=0x01):
  - 3-cycle high pulse on gpio_i[0] -> IN stays 0, no status.
  - 4-cycle pulse -> IN[0]=1 exactly 2+4 cycles after the pin rises, then STATUS[0]=1.
- Async reset mid-count: assert rst_n for 1 cycle while a pin counter is at 2 -> all state 0; no spurious status after release with gpio_i=0.

Source files
------------

// File: rtl/io_gpio_irq.sv
// GPIO controller with per-pin sync/glitch filter, edge-triggered sticky status and a level IRQ.
// Sits in the IO read-data daisy chain; unaddressed reads pass dma_io_rdata_in through.

module io_gpio_irq_pin #(
  parameter int DEB_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic rise_en,
  input  logic fall_en,
  output logic f,
  output logic ev
);
  logic s1, s, f_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s   <= 1'b0;
      f_d <= 1'b0;
    end else begin
      s1  <= pin;
      s   <= s1;
      f_d <= f;
    end
  end

  generate
    if (DEB_CYCLES == 0) begin : g_nofilt
      assign f = s;
    end else begin : g_filt
      localparam logic [7:0] LAST = 8'(DEB_CYCLES - 1);
      logic [7:0] cnt;
      logic       f_r;
      // f follows s only after s has disagreed for DEB_CYCLES consecutive cycles
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
          f_r <= 1'b0;
        end else if (s == f_r) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt <= '0;
          f_r <= s;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
      assign f = f_r;
    end
  endgenerate

  assign ev = (f & ~f_d & rise_en) | (~f & f_d & fall_en);
endmodule

module io_gpio_irq #(
  parameter int          NGPIO      = 8,
  parameter logic [13:0] BASE_ADR   = 14'h3F88,
  parameter int          DEB_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dma_io_we,
  input  logic [15:2]      dma_io_wadr,
  input  logic [31:0]      dma_io_wdata,
  input  logic [15:2]      dma_io_radr,
  input  logic             dma_io_radr_en,
  input  logic [31:0]      dma_io_rdata_in,
  output logic [31:0]      dma_io_rdata,
  input  logic [NGPIO-1:0] gpio_i,
  output logic [NGPIO-1:0] gpio_o,
  output logic [NGPIO-1:0] gpio_en,
  output logic             gpio_irq
);
  logic [13:0]      woff, roff;
  logic             whit, rhit;
  logic [7:0]       wsel;
  logic [NGPIO-1:0] wd, out_r, en_r, rise_r, fall_r, status_r, status_nxt, clr;
  logic [NGPIO-1:0] f_vec, ev_vec, rsel;
  logic             irq_r, rd_vld;
  logic [2:0]       rd_off;
  logic             unused_ok;

  assign woff = dma_io_wadr - BASE_ADR;
  assign roff = dma_io_radr - BASE_ADR;
  assign whit = dma_io_we && (woff < 14'd8);
  assign rhit = dma_io_radr_en && (roff < 14'd8);
  assign wsel = whit ? (8'b1 << woff[2:0]) : 8'b0;
  assign wd   = dma_io_wdata[NGPIO-1:0];
  assign unused_ok = ^dma_io_wdata;

  io_gpio_irq_pin #(.DEB_CYCLES(DEB_CYCLES)) u_pin [NGPIO-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin     (gpio_i),
    .rise_en (rise_r),
    .fall_en (fall_r),
    .f       (f_vec),
    .ev      (ev_vec)
  );

  // set has priority over a same-cycle W1C
  assign clr        = wsel[7] ? wd : '0;
  assign status_nxt = (status_r & ~clr) | ev_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r    <= '0;
      en_r     <= '0;
      rise_r   <= '0;
      fall_r   <= '0;
      status_r <= '0;
      irq_r    <= 1'b0;
      rd_vld   <= 1'b0;
      rd_off   <= '0;
    end else begin
      if (wsel[0])      out_r <= wd;
      else if (wsel[3]) out_r <= out_r | wd;
      else if (wsel[4]) out_r <= out_r & ~wd;
      if (wsel[2]) en_r   <= wd;
      if (wsel[5]) rise_r <= wd;
      if (wsel[6]) fall_r <= wd;
      status_r <= status_nxt;
      irq_r    <= |status_nxt;
      rd_vld   <= rhit;
      rd_off   <= roff[2:0];
    end
  end

  always_comb begin
    rsel = '0;
    case (rd_off)
      3'd0: rsel = out_r;
      3'd1: rsel = f_vec;
      3'd2: rsel = en_r;
      3'd5: rsel = rise_r;
      3'd6: rsel = fall_r;
      3'd7: rsel = status_r;
      default: rsel = '0;
    endcase
  end

  assign dma_io_rdata = rd_vld ? 32'(rsel) : dma_io_rdata_in;
  assign gpio_o   = out_r;
  assign gpio_en  = en_r;
  assign gpio_irq = irq_r;
endmodule

// File: tb/tb_io_gpio_irq.sv
// Directed bench: register vectors on an unfiltered instance, edge/IRQ and glitch-filter
// sequences on unfiltered and DEB_CYCLES=4 instances sharing one bus.
module tb_io_gpio_irq;
  localparam logic [13:0] BASE = 14'h3F88;
  localparam logic [3:0]  R_OUT = 4'd0, R_IN = 4'd1, R_EN = 4'd2, R_SET = 4'd3,
                          R_CLR = 4'd4, R_RISE = 4'd5, R_FALL = 4'd6, R_STAT = 4'd7;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        we = 1'b0, radr_en = 1'b0;
  logic [13:0] wadr = '0, radr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata_in = 32'hDEADBEEF;
  logic [31:0] rdata0, rdata4;
  logic [7:0]  gpio_i0 = 8'hFF, gpio_i4 = 8'h00;
  logic [7:0]  gpio_o0, gpio_en0, gpio_o4, gpio_en4;
  logic        irq0, irq4;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  io_gpio_irq #(.NGPIO(8), .BASE_ADR(BASE), .DEB_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .dma_io_we(we), .dma_io_wadr(wadr), .dma_io_wdata(wdata),
    .dma_io_radr(radr), .dma_io_radr_en(radr_en), .dma_io_rdata_in(rdata_in),
    .dma_io_rdata(rdata0), .gpio_i(gpio_i0), .gpio_o(gpio_o0), .gpio_en(gpio_en0),
    .gpio_irq(irq0));

  io_gpio_irq #(.NGPIO(8), .BASE_ADR(BASE), .DEB_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .dma_io_we(we), .dma_io_wadr(wadr), .dma_io_wdata(wdata),
    .dma_io_radr(radr), .dma_io_radr_en(radr_en), .dma_io_rdata_in(rdata_in),
    .dma_io_rdata(rdata4), .gpio_i(gpio_i4), .gpio_o(gpio_o4), .gpio_en(gpio_en4),
    .gpio_irq(irq4));

  typedef struct {
    logic        wr;
    logic [3:0]  woff;
    logic [31:0] wdat;
    logic [3:0]  roff;
    logic [31:0] exp_rd;
    logic [7:0]  exp_o;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    we = 1'b1; wadr = BASE + 14'(off); wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Strobe now, sample in the following cycle.
  task automatic rd(input logic [3:0] off, output logic [31:0] r0, output logic [31:0] r4);
    radr_en = 1'b1; radr = BASE + 14'(off);
    @(negedge clk);
    radr_en = 1'b0;
    r0 = rdata0; r4 = rdata4;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r0, r4;
    int n;

    vecs[0] = '{1'b1, R_OUT,  32'h000000A5, R_OUT,  32'h000000A5, 8'hA5};
    vecs[1] = '{1'b1, R_SET,  32'h0000000F, R_OUT,  32'h000000AF, 8'hAF};
    vecs[2] = '{1'b1, R_CLR,  32'h00000081, R_OUT,  32'h0000002E, 8'h2E};
    vecs[3] = '{1'b0, R_OUT,  32'h0,        R_SET,  32'h00000000, 8'h2E};
    vecs[4] = '{1'b0, R_OUT,  32'h0,        R_CLR,  32'h00000000, 8'h2E};
    vecs[5] = '{1'b1, R_EN,   32'hFFFFFF3C, R_EN,   32'h0000003C, 8'h2E};
    vecs[6] = '{1'b0, R_OUT,  32'h0,        4'd8,   32'hDEADBEEF, 8'h2E};
    vecs[7] = '{1'b1, R_IN,   32'h00000055, R_IN,   32'h000000FF, 8'h2E};
    vecs[8] = '{1'b1, 4'd9,   32'h00000000, R_OUT,  32'h0000002E, 8'h2E};
    vecs[9] = '{1'b1, R_RISE, 32'hFFFFFF00, R_RISE, 32'h00000000, 8'h2E};

    // reset with all pins high
    repeat (2) @(negedge clk);
    chk("rst_gpio_o", 32'(gpio_o0), 32'h0);
    chk("rst_gpio_en", 32'(gpio_en0), 32'h0);
    chk("rst_irq", 32'(irq0), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd(R_IN, r0, r4);   chk("rst_in", r0, 32'h000000FF);
    rd(R_STAT, r0, r4); chk("rst_status", r0, 32'h0);
    chk("rst_irq_after", 32'(irq0), 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) wr(vecs[i].woff, vecs[i].wdat);
      rd(vecs[i].roff, r0, r4);
      chk($sformatf("vec%0d_rdata", i), r0, vecs[i].exp_rd);
      chk($sformatf("vec%0d_gpio_o", i), 32'(gpio_o0), 32'(vecs[i].exp_o));
    end

    // edge interrupt: pin0 rises, pin1 falls
    gpio_i0 = 8'h02;
    repeat (4) @(negedge clk);
    wr(R_RISE, 32'h01);
    wr(R_FALL, 32'h02);
    rd(R_STAT, r0, r4); chk("edge_status_idle", r0, 32'h0);
    gpio_i0[0] = 1'b1;
    n = 0;
    while (!irq0 && n < 8) begin @(negedge clk); n++; end
    chk("edge_irq_rise", 32'(irq0), 32'h1);
    chk("edge_irq_within4", 32'(n <= 4), 32'h1);
    rd(R_STAT, r0, r4); chk("edge_status_rise", r0, 32'h01);
    gpio_i0[1] = 1'b0;
    repeat (4) @(negedge clk);
    rd(R_STAT, r0, r4); chk("edge_status_fall", r0, 32'h03);
    wr(R_STAT, 32'h01);
    rd(R_STAT, r0, r4); chk("w1c_status_partial", r0, 32'h02);
    chk("w1c_irq_held", 32'(irq0), 32'h1);
    wr(R_STAT, 32'h02);
    chk("w1c_irq_clear", 32'(irq0), 32'h0);

    // set and W1C on the same edge: set wins
    gpio_i0[0] = 1'b0;
    repeat (4) @(negedge clk);
    rd(R_STAT, r0, r4); chk("fall_disabled_ignored", r0, 32'h0);
    gpio_i0[0] = 1'b1;
    repeat (2) @(negedge clk);
    wr(R_STAT, 32'h01);
    chk("setwin_irq", 32'(irq0), 32'h1);
    rd(R_STAT, r0, r4); chk("setwin_status", r0, 32'h01);
    wr(R_STAT, 32'hFF);
    chk("clear_all_irq", 32'(irq0), 32'h0);

    // glitch filter: 3-cycle pulse rejected
    gpio_i4[0] = 1'b1;
    repeat (3) @(negedge clk);
    gpio_i4[0] = 1'b0;
    repeat (10) @(negedge clk);
    rd(R_IN, r0, r4);   chk("glitch3_in", r4, 32'h0);
    rd(R_STAT, r0, r4); chk("glitch3_status", r4, 32'h0);
    chk("glitch3_irq", 32'(irq4), 32'h0);

    // 4-cycle pulse accepted 6 cycles after the pin rises
    radr_en = 1'b1; radr = BASE + 14'(R_IN);
    gpio_i4[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) gpio_i4[0] = 1'b0;
      if (k == 5) chk("deb4_in_k5", rdata4, 32'h0);
      if (k == 6) begin
        chk("deb4_in_k6", rdata4, 32'h01);
        chk("deb4_irq_k6", 32'(irq4), 32'h0);
      end
      if (k == 7) chk("deb4_irq_k7", 32'(irq4), 32'h1);
    end
    radr_en = 1'b0;
    wr(R_STAT, 32'hFF);
    repeat (12) @(negedge clk);

    // async reset while pin0 counter sits at 2
    gpio_i4[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0; gpio_i4 = 8'h00; gpio_i0 = 8'h00;
    #1;
    chk("midrst_gpio_o", 32'(gpio_o0), 32'h0);
    chk("midrst_gpio_en", 32'(gpio_en0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_irq4", 32'(irq4), 32'h0);
    rd(R_STAT, r0, r4); chk("midrst_status", r4, 32'h0);
    rd(R_IN, r0, r4);   chk("midrst_in", r4, 32'h0);
    rd(R_RISE, r0, r4); chk("midrst_rise_en", r4, 32'h0);
    rd(R_OUT, r0, r4);  chk("midrst_out", r0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
